cdd_mod_updown_counter: RTL and testbench
=========================================

// Module: cdd_mod_updown_counter
// PURPOSE
//  Parametrised modulo-N synchronous up/down counter with synchronous clear,
//  parallel load, enable and cascade outputs. Generalises the fixed 8-bit mod-100
//  down counter to any width and modulus, adds count direction and terminal count,
//  and cascades through CEO. Used as a timer/divider macro in the behavioural library.
// PARAMETERS
//  WIDTH    8    counter/data width in bits; legal range 2..32
//  MODULUS  100  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//  RST_VAL  0    value loaded by CS; must be < MODULUS
// PORTS
//  CLK   in   1      clock; all state changes on the rising edge
//  CS    in   1      synchronous active-high reset/clear (highest priority)
//  LD    in   1      synchronous parallel load of D
//  EN    in   1      count enable
//  UP    in   1      direction: 1 = count up, 0 = count down
//  D     in   WIDTH  parallel load data
//  Q     out  WIDTH  counter value (registered)
//  TC    out  1      terminal count (combinational from Q, UP)
//  CEO   out  1      cascade enable out = EN & TC & !LD & !CS
//  OOR   out  1      out of range: Q >= MODULUS (combinational from Q)
//  WRAP  out  1      registered one-cycle pulse, high the cycle after a wrap
// BEHAVIOUR
//  - One clock (CLK). Reset is synchronous and active-high (CS). No async paths.
//  - Reset: CS=1 at an edge -> Q=RST_VAL, WRAP=0. TC/OOR/CEO follow from Q.
//  - Priority at each edge: CS > LD > EN count > hold.
//  - LD=1 (CS=0): Q<=D for any D, including D>=MODULUS. No range check on load.
//    WRAP<=0.
//  - EN=1, LD=0, CS=0, OOR=0:
//      UP=1: Q==MODULUS-1 -> Q<=0 and WRAP<=1; otherwise Q<=Q+1, WRAP<=0.
//      UP=0: Q==0 -> Q<=MODULUS-1 and WRAP<=1; otherwise Q<=Q-1, WRAP<=0.
//  - EN=1 with OOR=1: counting is inhibited. Q holds, WRAP<=0. Recover only by
//    CS or LD.
//  - EN=0: Q holds, WRAP<=0.
//  - TC = !OOR & (UP ? Q==MODULUS-1 : Q==0). TC is valid in the same cycle that
//    UP changes; there is no latency.
//  - CEO feeds the EN of the next stage. A chain of N stages counts modulo
//    MODULUS**N, and all stages wrap on the same edge.
//  - Arithmetic is WIDTH bits wide. With MODULUS == 2**WIDTH, MODULUS-1 is all
//    ones and the wrap equals natural overflow, so OOR is constantly 0. Compute
//    MODULUS-1 as a WIDTH-bit constant so the parameter expression cannot overflow.
//  - Direction change mid-count takes effect at the next enabled edge. There is
//    no extra state.
//  - CS asserted together with LD and/or EN: clear wins. LD together with EN:
//    load wins, and WRAP is not asserted.
//  - Power-up value is undefined until the first CS edge. The bench must apply CS
//    before checking anything.
// TESTING
//  1 Reset: CS=1 for 1 edge with LD=EN=1, D=8'h55 -> Q=0, WRAP=0, TC=0 (UP=1), OOR=0.
//  2 Up wrap, default params: LD D=98, then EN=1 UP=1 for 2 edges -> Q=99 (TC=1,
//    CEO=1), then Q=0 with WRAP=1 for exactly one cycle.
//  3 Down wrap: Q=1, EN=1 UP=0 -> Q=0 (TC=1), next edge Q=99, WRAP=1; UP=1 at
//    Q=99 -> TC=1 immediately.
//  4 Out of range: LD D=8'd200 -> OOR=1, TC=0; EN=1 for 5 edges -> Q stays 200;
//    LD D=5 -> OOR=0, counting resumes.
//  5 Cascade: two stages, WIDTH=4 MODULUS=10, low-stage CEO drives the high-stage
//    EN, both cleared; 100 enabled edges up -> both Q=0 and both WRAP pulse on
//    edge 100; the high stage increments only on edges 10, 20, ...
//  6 Full-range: WIDTH=4 MODULUS=16 -> counts 15->0 up and 0->15 down, WRAP on
//    each wrap, OOR never asserted; randomised CS/LD/EN/UP checked against a
//    reference model.

Source files
------------

// File: rtl/cdd_mod_updown_counter.sv
// Modulo-N synchronous up/down counter with clear, parallel load, enable,
// terminal count, out-of-range flag, wrap pulse and cascade enable output.
module cdd_mod_updown_counter #(
  parameter int unsigned          WIDTH   = 8,
  parameter longint unsigned      MODULUS = 100,
  parameter int unsigned          RST_VAL = 0
) (
  input  logic             CLK,
  input  logic             CS,
  input  logic             LD,
  input  logic             EN,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO,
  output logic             OOR,
  output logic             WRAP
);

  // Modulus is carried one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             oor;
  logic             at_max;
  logic             at_zero;

  assign oor     = ({1'b0, q_q} >= MOD_EXT);
  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (LD) begin
      q_d = D;
    end else if (EN && !oor) begin
      if (UP) begin
        if (at_max) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + ONE;
        end
      end else begin
        if (at_zero) begin
          q_d    = MAX_VAL;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CS) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign WRAP = wrap_q;
  assign OOR  = oor;
  assign TC   = !oor && (UP ? at_max : at_zero);
  // Next stage counts exactly when this one is about to wrap by counting.
  assign CEO  = EN && TC && !LD && !CS;

endmodule

// File: tb/tb_cdd_mod_updown_counter.sv
// Directed and model-checked bench for cdd_mod_updown_counter: default mod-100
// instance, a two-stage mod-10 cascade and a full-range mod-16 instance.
module tb_cdd_mod_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance: WIDTH=8, MODULUS=100
  logic       d_cs = 0, d_ld = 0, d_en = 0, d_up = 1;
  logic [7:0] d_d = 0;
  logic [7:0] d_q;
  logic       d_tc, d_ceo, d_oor, d_wrap;

  cdd_mod_updown_counter u_dflt (
    .CLK(clk), .CS(d_cs), .LD(d_ld), .EN(d_en), .UP(d_up), .D(d_d),
    .Q(d_q), .TC(d_tc), .CEO(d_ceo), .OOR(d_oor), .WRAP(d_wrap)
  );

  // two-stage cascade: WIDTH=4, MODULUS=10
  logic       c_cs = 0, c_en = 0, c_ld = 0, c_up = 1;
  logic [3:0] c_d = 0;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_ceo, lo_oor, lo_wrap;
  logic       hi_tc, hi_ceo, hi_oor, hi_wrap;

  cdd_mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_lo (
    .CLK(clk), .CS(c_cs), .LD(c_ld), .EN(c_en), .UP(c_up), .D(c_d),
    .Q(lo_q), .TC(lo_tc), .CEO(lo_ceo), .OOR(lo_oor), .WRAP(lo_wrap)
  );

  cdd_mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_hi (
    .CLK(clk), .CS(c_cs), .LD(c_ld), .EN(lo_ceo), .UP(c_up), .D(c_d),
    .Q(hi_q), .TC(hi_tc), .CEO(hi_ceo), .OOR(hi_oor), .WRAP(hi_wrap)
  );

  // full-range instance: WIDTH=4, MODULUS=16
  logic       f_cs = 0, f_ld = 0, f_en = 0, f_up = 1;
  logic [3:0] f_d = 0;
  logic [3:0] f_q;
  logic       f_tc, f_ceo, f_oor, f_wrap;

  cdd_mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) u_full (
    .CLK(clk), .CS(f_cs), .LD(f_ld), .EN(f_en), .UP(f_up), .D(f_d),
    .Q(f_q), .TC(f_tc), .CEO(f_ceo), .OOR(f_oor), .WRAP(f_wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    d_cs = 1; d_ld = 1; d_en = 1; d_up = 1; d_d = 8'h55;
    tick();
    d_cs = 0; d_ld = 0; d_en = 0;
    checks++; if (d_q !== 8'd0)  begin errors++; $display("FAIL reset_q got=%0d exp=0", d_q); end
    checks++; if (d_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", d_wrap); end
    checks++; if (d_tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", d_tc); end
    checks++; if (d_oor !== 1'b0) begin errors++; $display("FAIL reset_oor got=%b exp=0", d_oor); end
  endtask

  task automatic test_up_wrap();
    d_ld = 1; d_d = 8'd98; tick();
    d_ld = 0; d_en = 1; d_up = 1; tick();
    checks++; if (d_q !== 8'd99) begin errors++; $display("FAIL up_q99 got=%0d exp=99", d_q); end
    checks++; if (d_tc !== 1'b1) begin errors++; $display("FAIL up_tc got=%b exp=1", d_tc); end
    checks++; if (d_ceo !== 1'b1) begin errors++; $display("FAIL up_ceo got=%b exp=1", d_ceo); end
    tick();
    checks++; if (d_q !== 8'd0) begin errors++; $display("FAIL up_wrap_q got=%0d exp=0", d_q); end
    checks++; if (d_wrap !== 1'b1) begin errors++; $display("FAIL up_wrap_pulse got=%b exp=1", d_wrap); end
    d_en = 0; tick();
    checks++; if (d_wrap !== 1'b0) begin errors++; $display("FAIL up_wrap_one_cycle got=%b exp=0", d_wrap); end
    checks++; if (d_q !== 8'd0) begin errors++; $display("FAIL up_hold got=%0d exp=0", d_q); end
  endtask

  task automatic test_down_wrap();
    d_ld = 1; d_d = 8'd1; tick();
    d_ld = 0; d_en = 1; d_up = 0; tick();
    checks++; if (d_q !== 8'd0) begin errors++; $display("FAIL dn_q0 got=%0d exp=0", d_q); end
    checks++; if (d_tc !== 1'b1) begin errors++; $display("FAIL dn_tc got=%b exp=1", d_tc); end
    tick();
    checks++; if (d_q !== 8'd99) begin errors++; $display("FAIL dn_wrap_q got=%0d exp=99", d_q); end
    checks++; if (d_wrap !== 1'b1) begin errors++; $display("FAIL dn_wrap_pulse got=%b exp=1", d_wrap); end
    checks++; if (d_tc !== 1'b0) begin errors++; $display("FAIL dn_tc_at99 got=%b exp=0", d_tc); end
    d_en = 0; d_up = 1; #1;
    checks++; if (d_tc !== 1'b1) begin errors++; $display("FAIL dir_tc_immediate got=%b exp=1", d_tc); end
    tick();
    checks++; if (d_q !== 8'd99) begin errors++; $display("FAIL dir_hold got=%0d exp=99", d_q); end
    checks++; if (d_wrap !== 1'b0) begin errors++; $display("FAIL dir_wrap_clear got=%b exp=0", d_wrap); end
  endtask

  task automatic test_out_of_range();
    d_ld = 1; d_d = 8'd200; d_up = 1; tick();
    d_ld = 0;
    checks++; if (d_oor !== 1'b1) begin errors++; $display("FAIL oor_set got=%b exp=1", d_oor); end
    checks++; if (d_tc !== 1'b0) begin errors++; $display("FAIL oor_tc got=%b exp=0", d_tc); end
    d_en = 1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (d_q !== 8'd200) begin errors++; $display("FAIL oor_hold got=%0d exp=200", d_q); end
    checks++; if (d_wrap !== 1'b0) begin errors++; $display("FAIL oor_wrap got=%b exp=0", d_wrap); end
    checks++; if (d_ceo !== 1'b0) begin errors++; $display("FAIL oor_ceo got=%b exp=0", d_ceo); end
    d_ld = 1; d_d = 8'd5; d_en = 0; tick();
    d_ld = 0;
    checks++; if (d_oor !== 1'b0) begin errors++; $display("FAIL oor_clear got=%b exp=0", d_oor); end
    d_en = 1; tick();
    checks++; if (d_q !== 8'd6) begin errors++; $display("FAIL oor_resume got=%0d exp=6", d_q); end
    d_en = 0;
  endtask

  task automatic test_priority();
    d_ld = 1; d_d = 8'd99; d_up = 1; tick();
    d_ld = 1; d_d = 8'd10; d_en = 1; #1;
    checks++; if (d_ceo !== 1'b0) begin errors++; $display("FAIL prio_ceo_ld got=%b exp=0", d_ceo); end
    tick();
    checks++; if (d_q !== 8'd10) begin errors++; $display("FAIL prio_ld_q got=%0d exp=10", d_q); end
    checks++; if (d_wrap !== 1'b0) begin errors++; $display("FAIL prio_ld_wrap got=%b exp=0", d_wrap); end
    d_cs = 1; d_ld = 1; d_d = 8'd42; #1;
    checks++; if (d_ceo !== 1'b0) begin errors++; $display("FAIL prio_ceo_cs got=%b exp=0", d_ceo); end
    tick();
    d_cs = 0; d_ld = 0; d_en = 0;
    checks++; if (d_q !== 8'd0) begin errors++; $display("FAIL prio_cs_q got=%0d exp=0", d_q); end
  endtask

  task automatic test_cascade();
    c_cs = 1; c_en = 1; tick();
    c_cs = 0;
    checks++; if (lo_q !== 4'd0 || hi_q !== 4'd0) begin errors++; $display("FAIL casc_clear got=%0d/%0d exp=0/0", hi_q, lo_q); end
    for (int i = 1; i <= 100; i++) begin
      tick();
      checks++;
      if (lo_q !== 4'(i % 10) || hi_q !== 4'((i / 10) % 10)) begin
        errors++; $display("FAIL casc_count edge=%0d got=%0d/%0d exp=%0d/%0d", i, hi_q, lo_q, (i/10)%10, i%10);
      end
      checks++;
      if (lo_wrap !== (i % 10 == 0) || hi_wrap !== (i == 100)) begin
        errors++; $display("FAIL casc_wrap edge=%0d got=%b/%b exp=%b/%b", i, hi_wrap, lo_wrap, i == 100, i % 10 == 0);
      end
    end
    c_en = 0;
  endtask

  task automatic test_full_range();
    logic [3:0] m_q;
    logic       m_wrap;
    f_cs = 1; tick();
    f_cs = 0; m_q = 0; m_wrap = 0;
    f_en = 1; f_up = 1;
    for (int i = 1; i <= 16; i++) tick();
    checks++; if (f_q !== 4'd0 || f_wrap !== 1'b1) begin errors++; $display("FAIL full_up_wrap got=%0d/%b exp=0/1", f_q, f_wrap); end
    f_up = 0; tick();
    checks++; if (f_q !== 4'd15 || f_wrap !== 1'b1) begin errors++; $display("FAIL full_dn_wrap got=%0d/%b exp=15/1", f_q, f_wrap); end
    f_ld = 1; f_d = 4'd15; f_en = 0; tick();
    f_ld = 0;
    checks++; if (f_oor !== 1'b0) begin errors++; $display("FAIL full_oor15 got=%b exp=0", f_oor); end
    m_q = 4'd15; m_wrap = 0;
    for (int i = 0; i < 300; i++) begin
      f_cs = ($urandom_range(0, 15) == 0);
      f_ld = ($urandom_range(0, 7) == 0);
      f_en = ($urandom_range(0, 3) != 0);
      f_up = 1'($urandom_range(0, 1));
      f_d  = 4'($urandom_range(0, 15));
      if (f_cs) begin m_q = 0; m_wrap = 0; end
      else if (f_ld) begin m_q = f_d; m_wrap = 0; end
      else if (f_en && f_up) begin m_wrap = (m_q == 4'd15); m_q = (m_q == 4'd15) ? 4'd0 : m_q + 4'd1; end
      else if (f_en) begin m_wrap = (m_q == 4'd0); m_q = (m_q == 4'd0) ? 4'd15 : m_q - 4'd1; end
      else m_wrap = 0;
      tick();
      checks++;
      if (f_q !== m_q || f_wrap !== m_wrap || f_oor !== 1'b0 ||
          f_tc !== (f_up ? (m_q == 4'd15) : (m_q == 4'd0))) begin
        errors++; $display("FAIL full_rand step=%0d got q=%0d w=%b oor=%b tc=%b exp q=%0d w=%b", i, f_q, f_wrap, f_oor, f_tc, m_q, m_wrap);
      end
    end
    f_cs = 0; f_ld = 0; f_en = 0;
  endtask

  initial begin
    tick();
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_out_of_range();
    test_priority();
    test_cascade();
    test_full_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
